// File: rtl/spi_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
//  Module   : spi_ctrl_pkg
//  Purpose  : Shared state encoding and sizing constants for the SPI transfer
//             controller and its clock divider.
//  Revision : 1.0
// ----------------------------------------------------------------------------
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_HOLD  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam int BITS_BYTE       = 8;
  localparam int BITS_WORD       = 32;
  localparam int CLK_DIV_DEFAULT = 4;

endpackage : spi_ctrl_pkg
`default_nettype wire

// File: rtl/spi_clk_div.sv
`default_nettype none
// ----------------------------------------------------------------------------
//  Module   : spi_clk_div
//  Purpose  : Half-period counter; tick_o pulses on the last cycle of every
//             CLK_DIV-cycle window and the count restarts after each tick.
//  Revision : 1.0
// ----------------------------------------------------------------------------
module spi_clk_div
  import spi_ctrl_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [7:0] LAST_CNT = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign tick_o = en_i && (cnt_q == LAST_CNT);

  // Every FSM state change happens on a tick, so clearing here restarts the
  // window on each state entry.
  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (!en_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : spi_clk_div
`default_nettype wire

// File: rtl/spi_xfer_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
//  Module   : spi_xfer_ctrl
//  Purpose  : SPI mode-0 master moving one 8- or 32-bit word per start, MSB
//             first, with registered outputs and a one-cycle done pulse.
//  Revision : 1.0
// ----------------------------------------------------------------------------
module spi_xfer_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        width_sel,
  input  logic [31:0] tx_data,
  output logic [31:0] rx_data,
  output logic        busy,
  output logic        done,
  output logic        spi_sck,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  state_e      state_q;
  logic [31:0] tx_sh_q;
  logic [31:0] rx_sh_q;
  logic [31:0] rx_q;
  logic [5:0]  bit_cnt_q;
  logic        byte_mode_q;
  logic        busy_q;
  logic        done_q;
  logic        sck_q;
  logic        cs_n_q;
  logic        mosi_q;

  logic        tick;
  logic        div_en;
  logic [5:0]  bit_cnt_inc;
  logic [5:0]  xfer_bits;

  assign div_en      = (state_q == ST_SETUP) || (state_q == ST_HIGH) ||
                       (state_q == ST_LOW)   || (state_q == ST_HOLD);
  assign bit_cnt_inc = bit_cnt_q + 6'd1;
  assign xfer_bits   = byte_mode_q ? 6'(BITS_BYTE) : 6'(BITS_WORD);

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (div_en),
    .tick_o  (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      rx_q        <= '0;
      bit_cnt_q   <= '0;
      byte_mode_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sck_q       <= 1'b0;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            // Byte mode is left-aligned so the shifter always emits bit 31.
            byte_mode_q <= width_sel;
            tx_sh_q     <= width_sel ? {tx_data[7:0], 24'h0} : tx_data;
            mosi_q      <= width_sel ? tx_data[7] : tx_data[31];
            rx_sh_q     <= '0;
            bit_cnt_q   <= '0;
            cs_n_q      <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tick) begin
            sck_q   <= 1'b1;
            state_q <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (tick) begin
            rx_sh_q   <= {rx_sh_q[30:0], spi_miso};
            bit_cnt_q <= bit_cnt_inc;
            sck_q     <= 1'b0;
            if (bit_cnt_inc == xfer_bits) begin
              state_q <= ST_HOLD;
            end else begin
              tx_sh_q <= {tx_sh_q[30:0], 1'b0};
              mosi_q  <= tx_sh_q[30];
              state_q <= ST_LOW;
            end
          end
        end
        ST_LOW: begin
          if (tick) begin
            sck_q   <= 1'b1;
            state_q <= ST_HIGH;
          end
        end
        ST_HOLD: begin
          if (tick) begin
            cs_n_q  <= 1'b1;
            done_q  <= 1'b1;
            mosi_q  <= 1'b0;
            rx_q    <= byte_mode_q ? {24'h0, rx_sh_q[7:0]} : rx_sh_q;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q    <= 1'b0;
          busy_q    <= 1'b0;
          bit_cnt_q <= '0;
          state_q   <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rx_data  = rx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign spi_sck  = sck_q;
  assign spi_cs_n = cs_n_q;
  assign spi_mosi = mosi_q;

endmodule : spi_xfer_ctrl
`default_nettype wire

// File: tb/tb_spi_xfer_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
//  Module   : tb_spi_xfer_ctrl
//  Purpose  : Self-checking bench for spi_xfer_ctrl at CLK_DIV=4 and CLK_DIV=2.
//  Revision : 1.0
// ----------------------------------------------------------------------------
module tb_spi_xfer_ctrl;

  logic        clk = 1'b0;
  logic [1:0]  reset_n;
  logic [1:0]  start;
  logic [1:0]  width_sel;
  logic [31:0] tx_data [2];
  logic [31:0] rx_data [2];
  logic [1:0]  busy;
  logic [1:0]  done;
  logic [1:0]  spi_sck;
  logic [1:0]  spi_cs_n;
  logic [1:0]  spi_mosi;
  logic [1:0]  spi_miso;
  logic [1:0]  loop;
  logic [1:0]  slave_miso;

  logic [31:0] slave_word [2];
  int          slave_n    [2];

  // Monitor state per instance
  int          pulses   [2];
  logic [31:0] mosi_cap [2];
  int          hi_run   [2];
  int          lo_run   [2];
  int          cs_hi    [2];
  int          sidx     [2];
  bit          seen     [2];
  logic        prev_sck [2];
  logic        prev_cs  [2];
  logic        prev_mo  [2];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  assign spi_miso = (loop & spi_mosi) | (~loop & slave_miso);

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    spi_xfer_ctrl #(
      .CLK_DIV (gi == 0 ? 4 : 2)
    ) u_dut (
      .clk       (clk),
      .reset_n   (reset_n[gi]),
      .start     (start[gi]),
      .width_sel (width_sel[gi]),
      .tx_data   (tx_data[gi]),
      .rx_data   (rx_data[gi]),
      .busy      (busy[gi]),
      .done      (done[gi]),
      .spi_sck   (spi_sck[gi]),
      .spi_cs_n  (spi_cs_n[gi]),
      .spi_mosi  (spi_mosi[gi]),
      .spi_miso  (spi_miso[gi])
    );
  end

  function automatic int div_of(input int d);
    return (d == 0) ? 4 : 2;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endfunction

  // Bus monitor and SPI slave model, both derived from the observed pins.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset_n[d]) begin
        pulses[d] = 0; mosi_cap[d] = '0; hi_run[d] = 0; lo_run[d] = 0;
        cs_hi[d] = 0; sidx[d] = 0; seen[d] = 1'b0;
        prev_sck[d] = 1'b0; prev_cs[d] = 1'b1; prev_mo[d] = 1'b0;
      end else begin
        if (!spi_cs_n[d] && prev_cs[d]) begin
          if (seen[d]) chk("cs_high_gap_ge2", 32'(cs_hi[d] >= 2), 32'd1);
          pulses[d] = 0; mosi_cap[d] = '0; sidx[d] = 0; cs_hi[d] = 0;
        end
        if (spi_cs_n[d] && !prev_cs[d]) seen[d] = 1'b1;
        if (spi_cs_n[d]) begin
          cs_hi[d]++;
          sidx[d] = 0;
        end
        if (spi_mosi[d] !== prev_mo[d]) chk("mosi_change_sck", 32'(spi_sck[d]), 32'd0);
        if (spi_sck[d] && !prev_sck[d]) begin
          chk("sck_low_half", 32'(lo_run[d]), 32'(div_of(d)));
          lo_run[d] = 0; hi_run[d] = 1; pulses[d]++;
          mosi_cap[d] = {mosi_cap[d][30:0], spi_mosi[d]};
        end else if (spi_sck[d]) begin
          hi_run[d]++;
        end else if (prev_sck[d]) begin
          chk("sck_high_half", 32'(hi_run[d]), 32'(div_of(d)));
          hi_run[d] = 0; lo_run[d] = 1; sidx[d]++;
        end else if (!spi_cs_n[d]) begin
          lo_run[d]++;
        end else begin
          lo_run[d] = 0;
        end
        prev_sck[d] = spi_sck[d];
        prev_cs[d]  = spi_cs_n[d];
        prev_mo[d]  = spi_mosi[d];
      end
      slave_miso[d] = (sidx[d] < slave_n[d]) ? slave_word[d][slave_n[d] - 1 - sidx[d]] : 1'b0;
    end
  end

  // Counts cycles from the accepting edge until done is seen.
  task automatic wait_done(input int d, input bit hold, input bit scram, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!hold) start[d] = 1'b0;
      if (scram) begin
        tx_data[d]   = $urandom;
        width_sel[d] = 1'($urandom_range(0, 1));
      end
    end while (!done[d] && lat < 2000);
    if (!done[d]) chk("done_timeout", 32'(done[d]), 32'd1);
  endtask

  task automatic run_xfer(input int d, input bit w, input logic [31:0] tx, input bit lp,
                          input logic [31:0] sw, input bit hold, input bit scram,
                          output logic [31:0] rx, output int lat, output int np,
                          output logic [31:0] mcap);
    @(negedge clk);
    width_sel[d]  = w;
    tx_data[d]    = tx;
    loop[d]       = lp;
    slave_word[d] = sw;
    slave_n[d]    = w ? 8 : 32;
    start[d]      = 1'b1;
    @(posedge clk);
    wait_done(d, hold, scram, lat);
    rx   = rx_data[d];
    np   = pulses[d];
    mcap = mosi_cap[d];
  endtask

  typedef struct {
    int          d;
    bit          w;
    logic [31:0] tx;
    bit          lp;
    logic [31:0] sw;
    logic [31:0] exp_rx;
    int          exp_lat;
    int          exp_np;
    logic [31:0] exp_mosi;
  } vec_t;

  vec_t tbl [5];

  initial begin
    logic [31:0] rx, mcap, exp_rx, exp_mo, tx, sw;
    int          lat, np, n, nb;
    bit          w;

    tbl[0] = '{0, 1'b1, 32'h0000_00A5, 1'b1, 32'h0,         32'h0000_00A5, 69,  8,  32'h0000_00A5};
    tbl[1] = '{1, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'h0,         32'hDEAD_BEEF, 131, 32, 32'hDEAD_BEEF};
    tbl[2] = '{0, 1'b1, 32'h0000_003C, 1'b0, 32'hFFFF_FFFF, 32'h0000_00FF, 69,  8,  32'h0000_003C};
    tbl[3] = '{1, 1'b1, 32'hFFFF_FF00, 1'b0, 32'h1234_5681, 32'h0000_0081, 35,  8,  32'h0000_0000};
    tbl[4] = '{0, 1'b0, 32'h8000_0001, 1'b0, 32'h0,         32'h0000_0000, 261, 32, 32'h8000_0001};

    reset_n = 2'b00; start = 2'b00; width_sel = 2'b00; loop = 2'b00;
    for (int d = 0; d < 2; d++) begin
      tx_data[d] = '0; slave_word[d] = '0; slave_n[d] = 8;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_cs_n", 32'(spi_cs_n[d]), 32'd1);
      chk("rst_sck",  32'(spi_sck[d]),  32'd0);
      chk("rst_mosi", 32'(spi_mosi[d]), 32'd0);
      chk("rst_busy", 32'(busy[d]),     32'd0);
      chk("rst_done", 32'(done[d]),     32'd0);
      chk("rst_rx",   rx_data[d],       32'd0);
    end
    #1 reset_n = 2'b11;

    // Directed vectors
    for (int i = 0; i < 5; i++) begin
      run_xfer(tbl[i].d, tbl[i].w, tbl[i].tx, tbl[i].lp, tbl[i].sw, 1'b0, 1'b1, rx, lat, np, mcap);
      chk("vec_rx",      rx,          tbl[i].exp_rx);
      chk("vec_latency", 32'(lat),    32'(tbl[i].exp_lat));
      chk("vec_pulses",  32'(np),     32'(tbl[i].exp_np));
      chk("vec_mosi",    mcap,        tbl[i].exp_mosi);
      chk("vec_busy_dn", 32'(busy[tbl[i].d]), 32'd1);
      @(negedge clk);
      chk("vec_done_1cy", 32'(done[tbl[i].d]), 32'd0);
      chk("vec_busy_idle", 32'(busy[tbl[i].d]), 32'd0);
      repeat (3) @(negedge clk);
      chk("vec_rx_hold", rx_data[tbl[i].d], tbl[i].exp_rx);
    end

    // start held high through a transfer: one transfer, next only from IDLE
    run_xfer(0, 1'b1, 32'h0000_005A, 1'b1, 32'h0, 1'b1, 1'b0, rx, lat, np, mcap);
    chk("hold_rx",      rx,       32'h0000_005A);
    chk("hold_latency", 32'(lat), 32'd69);
    chk("hold_pulses",  32'(np),  32'd8);
    @(negedge clk);
    chk("hold_idle_busy", 32'(busy[0]),     32'd0);
    chk("hold_idle_cs",   32'(spi_cs_n[0]), 32'd1);
    tx_data[0] = 32'h0000_00C3;
    @(posedge clk);
    wait_done(0, 1'b0, 1'b0, lat);
    chk("hold2_latency", 32'(lat), 32'd69);
    chk("hold2_rx", rx_data[0], 32'h0000_00C3);

    // Reset during bit 5 of a 32-bit transfer
    @(negedge clk);
    width_sel[0] = 1'b0; tx_data[0] = 32'h0F1E_2D3C; loop[0] = 1'b1; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    n = 0;
    while (pulses[0] < 5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_bit5", 32'(pulses[0] >= 5), 32'd1);
    #1 reset_n[0] = 1'b0;
    #1;
    chk("abort_cs_n", 32'(spi_cs_n[0]), 32'd1);
    chk("abort_sck",  32'(spi_sck[0]),  32'd0);
    chk("abort_busy", 32'(busy[0]),     32'd0);
    chk("abort_rx",   rx_data[0],       32'd0);
    repeat (2) @(negedge clk);
    #1 reset_n[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done[0]), 32'd0);
    end
    run_xfer(0, 1'b0, 32'h1357_9BDF, 1'b1, 32'h0, 1'b0, 1'b0, rx, lat, np, mcap);
    chk("post_abort_rx",  rx,       32'h1357_9BDF);
    chk("post_abort_lat", 32'(lat), 32'd261);

    // Randomized transfers against the slave model
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 12; i++) begin
        w  = 1'($urandom_range(0, 1));
        tx = $urandom;
        sw = $urandom;
        nb = w ? 8 : 32;
        exp_rx = w ? {24'h0, sw[7:0]} : sw;
        exp_mo = w ? {24'h0, tx[7:0]} : tx;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        run_xfer(d, w, tx, 1'b0, sw, 1'b0, 1'b1, rx, lat, np, mcap);
        chk("rand_rx",      rx,       exp_rx);
        chk("rand_latency", 32'(lat), 32'(1 + div_of(d) * (2 * nb + 1)));
        chk("rand_pulses",  32'(np),  32'(nb));
        chk("rand_mosi",    mcap,     exp_mo);
      end
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_spi_xfer_ctrl
`default_nettype wire
